scpu_io_bridge: RTL and testbench
=================================

# scpu_io_bridge

Parametrised external I/O bridge between the SCPU core and the outside world, replacing the single fixed 8-bit in/out path. It samples `IN_CH` external input channels with per-channel change flags for CPU polling. It also buffers CPU output writes in a `OUT_DEPTH`-entry FIFO drained via a valid/ready handshake. It sits between the core's I/O instructions and the top-level pins.

## Interface
Parameters:
- `DATA_W`, 8: width of every data word (in channels, CPU bus, `ext_out`).
- `IN_CH`, 4: number of external input channels, 1..16.
- `OUT_DEPTH`, 4: output FIFO depth, power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ext_in`  in  `IN_CH*DATA_W`  external inputs, channel k at bits `[k*DATA_W +: DATA_W]`.
- `cpu_rd`  in  1  read strobe, one cycle.
- `cpu_ch`  in  `$clog2(IN_CH)` (min 1)  channel index for `cpu_rd`.
- `cpu_rd_data`  out  `DATA_W`  read result.
- `cpu_rd_valid`  out  1  `cpu_rd_data` valid, one-cycle pulse.
- `in_changed`  out  `IN_CH`  per-channel sticky "new value since last read".
- `cpu_wr`  in  1  write strobe into output FIFO.
- `cpu_wr_data`  in  `DATA_W`  write data.
- `cpu_wr_ready`  out  1  FIFO not full.
- `ext_out`  out  `DATA_W`  FIFO head.
- `ext_out_valid`  out  1  FIFO not empty.
- `ext_out_ready`  in  1  downstream accepts head.
- `out_overflow`  out  1  sticky: a write was dropped.
- `clr_overflow`  in  1  clears `out_overflow`.

## Operation
- Input sampling: every cycle `in_q[k] <= ext_in[k]`. The `prev_q[k]` register holds the previous sample.
- `in_changed[k]` sets when `in_q[k] != prev_q[k]`. It clears when `cpu_rd` is asserted with `cpu_ch==k`. Simultaneous set and clear on the same channel: set wins.
- Read: on `cpu_rd`, `cpu_rd_data <= in_q[cpu_ch]` and `cpu_rd_valid <= 1`. Otherwise `cpu_rd_valid <= 0` and `cpu_rd_data` holds.
- `cpu_ch >= IN_CH`: `cpu_rd_data <= 0`, `cpu_rd_valid <= 1`, no flag cleared.
- Output FIFO:
  - Push accepted iff `cpu_wr && !full`. Full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
  - Dropped write sets `out_overflow`.
  - Pop when `ext_out_valid && ext_out_ready`.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
  - Push while empty: no pop that cycle, entry visible next cycle.
- Pointers: `$clog2(OUT_DEPTH)` bits and wrap naturally. Count: `$clog2(OUT_DEPTH+1)` bits.
- `ext_out` is forced to 0 whenever `ext_out_valid` is 0.
- `clr_overflow` together with a dropped write: set wins.
- No FSM beyond FIFO occupancy (EMPTY / PARTIAL / FULL, derived from count).

## Timing
- Reset values:
  - `cpu_rd_data=0`, `cpu_rd_valid=0`, `in_changed=0`.
  - `ext_out=0`, `ext_out_valid=0`, `cpu_wr_ready=1`, `out_overflow=0`.
  - FIFO pointers and count 0; `in_q`/`prev_q` 0.
- Reset asserted mid-operation empties the FIFO and clears all flags on that edge. Buffered data is lost.
- Input latency: an `ext_in` change at edge N is in `in_q` after N. `in_changed` rises after edge N+1.
- Read latency: `cpu_rd` sampled at edge N gives `cpu_rd_valid`/`cpu_rd_data` after edge N.
- Write-to-output latency: push at edge N raises `ext_out_valid` after edge N.
- `cpu_wr_ready`, `ext_out_valid` and `ext_out` are combinational from count/head registers only, never from same-cycle inputs.
- Back-to-back pushes and pops every cycle are sustained at full throughput.

## Structure
- Package `scpu_io_pkg` holds:
  - `DATA_W` default constant.
  - `ch_idx_w(n)` function (`$clog2` with minimum 1).
  - `OUT_DEPTH` default.
- One sub-module, `scpu_out_fifo`:
  - Parametrised on `DATA_W`/`OUT_DEPTH`.
  - Ports: push/pop/full/empty/head/overflow.
- Input sampling and read mux stay in the top.

## Test plan
- Reset with `ext_in`=0x0F on all channels, `rst` high 3 cycles -> all outputs at reset values. `in_changed`=all-ones 2 cycles after release, then hold.
- Ch2 changes 0x0F->0xA5; `cpu_rd`, `cpu_ch`=2 on the cycle `in_changed[2]` rises -> `cpu_rd_data`=0xA5, `cpu_rd_valid` one pulse, `in_changed[2]` stays 0 afterwards. Repeat the read in the same cycle as a further change -> flag stays 1 (set wins).
- Push 0x11,0x22,0x33,0x44 with `ext_out_ready`=0 -> `cpu_wr_ready`=0 after 4th. Push 0x55 -> dropped, `out_overflow`=1. Then `ready`=1 -> outputs 0x11..0x44 in order, `ext_out`=0 after drain.
- Full FIFO, `cpu_wr` and pop in the same cycle -> write dropped, count 3, overflow set. `clr_overflow` alone -> overflow clears next cycle.
- Continuous push and pop for 20 cycles with `OUT_DEPTH`=4 -> pointers wrap ≥4 times, `ext_out` sequence matches input, no overflow.
- `rst` asserted with 3 entries queued -> `ext_out_valid`=0 and `cpu_wr_ready`=1 after that edge. First post-reset push appears at `ext_out` next cycle.

Source files
------------

// File: rtl/scpu_io_pkg.sv
// Shared constants and helpers for the SCPU external I/O bridge.
// Occupancy codes describe the output FIFO state, derived from its count.
package scpu_io_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_OUT_DEPTH = 4;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  // The channel index needs at least one bit, even when there is only one channel.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scpu_out_fifo.sv
// CPU-to-pin output FIFO. The head is registered state, and it reads as zero when the FIFO is empty.
// A write into a full FIFO is dropped and sets a sticky overflow flag.
module scpu_out_fifo
  import scpu_io_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clr_overflow,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic              overflow
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [OUT_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic [CW-1:0]                    count;
  logic [1:0]                       occ;
  logic                             do_push, do_pop, drop;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)                 occ = OCC_EMPTY;
    else if (count == CW'(OUT_DEPTH)) occ = OCC_FULL;
  end

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == OCC_EMPTY);

  // Full is judged on the pre-pop count, so a write while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= drop | (overflow & ~clr_overflow);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scpu_io_bridge.sv
// External I/O bridge for the SCPU core. It samples the input channels and keeps a sticky change flag for each one.
// CPU writes go out to the pins through a small valid/ready FIFO.
module scpu_io_bridge
  import scpu_io_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IN_CH     = 4,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH,
  localparam int CHW      = ch_idx_w(IN_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_CH*DATA_W-1:0] ext_in,
  input  logic                    cpu_rd,
  input  logic [CHW-1:0]          cpu_ch,
  output logic [DATA_W-1:0]       cpu_rd_data,
  output logic                    cpu_rd_valid,
  output logic [IN_CH-1:0]        in_changed,
  input  logic                    cpu_wr,
  input  logic [DATA_W-1:0]       cpu_wr_data,
  output logic                    cpu_wr_ready,
  output logic [DATA_W-1:0]       ext_out,
  output logic                    ext_out_valid,
  input  logic                    ext_out_ready,
  output logic                    out_overflow,
  input  logic                    clr_overflow
);

  logic [IN_CH-1:0][DATA_W-1:0] in_q, prev_q;
  logic                         ch_ok;
  logic                         full, empty;

  assign ch_ok = (int'(cpu_ch) < IN_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= ext_in;
      prev_q <= in_q;
    end
  end

  // When a change and a read of the same channel fall in one cycle, the change wins, so the new value is not missed.
  for (genvar k = 0; k < IN_CH; k++) begin : g_chg
    logic set_k, clr_k;
    assign set_k = (in_q[k] != prev_q[k]);
    assign clr_k = cpu_rd && ch_ok && (cpu_ch == CHW'(k));
    always_ff @(posedge clk) begin
      if (rst) in_changed[k] <= 1'b0;
      else     in_changed[k] <= set_k | (in_changed[k] & ~clr_k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= cpu_rd;
      if (cpu_rd) cpu_rd_data <= ch_ok ? in_q[cpu_ch] : '0;
    end
  end

  scpu_out_fifo #(
    .DATA_W   (DATA_W),
    .OUT_DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (cpu_wr),
    .push_data   (cpu_wr_data),
    .pop         (ext_out_ready),
    .clr_overflow(clr_overflow),
    .full        (full),
    .empty       (empty),
    .head        (ext_out),
    .overflow    (out_overflow)
  );

  assign cpu_wr_ready  = !full;
  assign ext_out_valid = !empty;

endmodule

// File: tb/tb_scpu_io_bridge.sv
// Self-checking bench for scpu_io_bridge. A cycle model feeds a scoreboard of expected outputs.
// Scenario tasks add explicit checks for the documented cases.
module tb_scpu_io_bridge;
  localparam int DW = 8, NCH = 3, DEPTH = 4, CHW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ext_in;
  logic              cpu_rd;
  logic [CHW-1:0]    cpu_ch;
  logic [DW-1:0]     cpu_rd_data;
  logic              cpu_rd_valid;
  logic [NCH-1:0]    in_changed;
  logic              cpu_wr;
  logic [DW-1:0]     cpu_wr_data;
  logic              cpu_wr_ready;
  logic [DW-1:0]     ext_out;
  logic              ext_out_valid;
  logic              ext_out_ready;
  logic              out_overflow;
  logic              clr_overflow;

  scpu_io_bridge #(.DATA_W(DW), .IN_CH(NCH), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ext_in(ext_in),
    .cpu_rd(cpu_rd), .cpu_ch(cpu_ch), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
    .in_changed(in_changed), .cpu_wr(cpu_wr), .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
    .ext_out(ext_out), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .out_overflow(out_overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit armed = 0;

  logic [NCH-1:0][DW-1:0] m_in = '0, m_prev = '0;
  logic [NCH-1:0]         m_chg = '0;
  logic [DW-1:0]          m_rd_data = '0;
  logic                   m_rd_valid = 1'b0;
  logic                   m_ovf = 1'b0;
  int                     m_count = 0;
  logic [DW-1:0]          sb[$];
  logic [DW-1:0]          popped[$];

  // Compare the DUT against the model state, advance the model across one rising edge, then land on the next falling edge.
  task automatic tick();
    logic [DW-1:0] exp_out;
    logic          push, pop;
    int            ch;
    if (armed) begin
      exp_out = (sb.size() > 0) ? sb[0] : '0;
      checks++; if (cpu_wr_ready !== (m_count < DEPTH)) begin failures++; $display("FAIL sb_wr_ready got=%b exp=%b", cpu_wr_ready, (m_count < DEPTH)); end
      checks++; if (ext_out_valid !== (m_count > 0)) begin failures++; $display("FAIL sb_out_valid got=%b exp=%b", ext_out_valid, (m_count > 0)); end
      checks++; if (ext_out !== exp_out) begin failures++; $display("FAIL sb_ext_out got=%h exp=%h", ext_out, exp_out); end
      checks++; if (out_overflow !== m_ovf) begin failures++; $display("FAIL sb_overflow got=%b exp=%b", out_overflow, m_ovf); end
      checks++; if (in_changed !== m_chg) begin failures++; $display("FAIL sb_in_changed got=%b exp=%b", in_changed, m_chg); end
      checks++; if (cpu_rd_valid !== m_rd_valid) begin failures++; $display("FAIL sb_rd_valid got=%b exp=%b", cpu_rd_valid, m_rd_valid); end
      checks++; if (cpu_rd_data !== m_rd_data) begin failures++; $display("FAIL sb_rd_data got=%h exp=%h", cpu_rd_data, m_rd_data); end
    end
    if (rst) begin
      m_in = '0; m_prev = '0; m_chg = '0; m_rd_data = '0; m_rd_valid = 1'b0;
      m_ovf = 1'b0; m_count = 0; sb.delete();
    end else begin
      pop  = (m_count > 0) && ext_out_ready;
      push = cpu_wr && (m_count < DEPTH);
      if (pop)  popped.push_back(sb.pop_front());
      if (push) sb.push_back(cpu_wr_data);
      m_count = m_count + int'(push) - int'(pop);
      if (cpu_wr && !push) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      ch = int'(cpu_ch);
      m_rd_valid = cpu_rd;
      if (cpu_rd) m_rd_data = (ch < NCH) ? m_in[ch] : '0;
      for (int k = 0; k < NCH; k++)
        m_chg[k] = (m_in[k] != m_prev[k]) | (m_chg[k] & ~(cpu_rd && ch == k));
      m_prev = m_in;
      m_in   = ext_in;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_in = {NCH{8'h0F}}; cpu_rd = 0; cpu_ch = 0; cpu_wr = 0; cpu_wr_data = 0;
    ext_out_ready = 0; clr_overflow = 0;
    repeat (3) begin tick(); armed = 1; end
    checks++; if ({cpu_rd_data, cpu_rd_valid, in_changed} !== '0) begin failures++; $display("FAIL reset_rd got=%h/%b/%b exp=0/0/0", cpu_rd_data, cpu_rd_valid, in_changed); end
    checks++; if ({ext_out, ext_out_valid, cpu_wr_ready, out_overflow} !== {8'h00, 3'b010}) begin failures++; $display("FAIL reset_out got=%h/%b/%b/%b exp=00/0/1/0", ext_out, ext_out_valid, cpu_wr_ready, out_overflow); end
    rst = 1'b0;
    tick();
    checks++; if (in_changed !== 3'b000) begin failures++; $display("FAIL chg_release1 got=%b exp=000", in_changed); end
    tick();
    checks++; if (in_changed !== 3'b111) begin failures++; $display("FAIL chg_release2 got=%b exp=111", in_changed); end
    tick();
    checks++; if (in_changed !== 3'b111) begin failures++; $display("FAIL chg_hold got=%b exp=111", in_changed); end
  endtask

  task automatic test_read();
    cpu_rd = 1; cpu_ch = 2; tick(); cpu_rd = 0;
    checks++; if ({cpu_rd_valid, cpu_rd_data, in_changed} !== {1'b1, 8'h0F, 3'b011}) begin failures++; $display("FAIL rd_first got=%b/%h/%b exp=1/0f/011", cpu_rd_valid, cpu_rd_data, in_changed); end
    ext_in[2*DW +: DW] = 8'hA5; tick();
    checks++; if (in_changed[2] !== 1'b0) begin failures++; $display("FAIL chg_lat0 got=%b exp=0", in_changed[2]); end
    tick();
    checks++; if (in_changed[2] !== 1'b1) begin failures++; $display("FAIL chg_lat1 got=%b exp=1", in_changed[2]); end
    cpu_rd = 1; cpu_ch = 2; tick(); cpu_rd = 0;
    checks++; if ({cpu_rd_valid, cpu_rd_data, in_changed[2]} !== {1'b1, 8'hA5, 1'b0}) begin failures++; $display("FAIL rd_a5 got=%b/%h/%b exp=1/a5/0", cpu_rd_valid, cpu_rd_data, in_changed[2]); end
    tick();
    checks++; if ({cpu_rd_valid, cpu_rd_data, in_changed[2]} !== {1'b0, 8'hA5, 1'b0}) begin failures++; $display("FAIL rd_hold got=%b/%h/%b exp=0/a5/0", cpu_rd_valid, cpu_rd_data, in_changed[2]); end
    ext_in[2*DW +: DW] = 8'h5A; tick();
    cpu_rd = 1; cpu_ch = 2; tick(); cpu_rd = 0;
    checks++; if ({cpu_rd_data, in_changed[2]} !== {8'h5A, 1'b1}) begin failures++; $display("FAIL rd_set_wins got=%h/%b exp=5a/1", cpu_rd_data, in_changed[2]); end
    cpu_rd = 1; cpu_ch = 3; tick(); cpu_rd = 0;
    checks++; if ({cpu_rd_valid, cpu_rd_data, in_changed} !== {1'b1, 8'h00, 3'b111}) begin failures++; $display("FAIL rd_oob got=%b/%h/%b exp=1/00/111", cpu_rd_valid, cpu_rd_data, in_changed); end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    popped.delete(); ext_out_ready = 0;
    for (int i = 0; i < 4; i++) begin cpu_wr = 1; cpu_wr_data = vals[i]; tick(); end
    checks++; if (cpu_wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", cpu_wr_ready); end
    cpu_wr_data = 8'h55; tick(); cpu_wr = 0;
    checks++; if (out_overflow !== 1'b1) begin failures++; $display("FAIL drop_ovf got=%b exp=1", out_overflow); end
    ext_out_ready = 1;
    for (int i = 0; i < 10 && ext_out_valid; i++) tick();
    checks++; if (popped.size() != 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== vals[i]) begin failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, popped[i], vals[i]); end
    end
    checks++; if ({ext_out, ext_out_valid} !== 9'h0) begin failures++; $display("FAIL drained_out got=%h/%b exp=00/0", ext_out, ext_out_valid); end
    ext_out_ready = 0;
  endtask

  task automatic test_full_pop();
    clr_overflow = 1; tick(); clr_overflow = 0;
    popped.delete();
    for (int i = 0; i < 4; i++) begin cpu_wr = 1; cpu_wr_data = 8'hA1 + DW'(i); tick(); end
    cpu_wr_data = 8'h66; ext_out_ready = 1; tick(); cpu_wr = 0; ext_out_ready = 0;
    checks++; if ({cpu_wr_ready, out_overflow, ext_out} !== {2'b11, 8'hA2}) begin failures++; $display("FAIL full_pop got=%b/%b/%h exp=1/1/a2", cpu_wr_ready, out_overflow, ext_out); end
    clr_overflow = 1; tick(); clr_overflow = 0;
    checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", out_overflow); end
    ext_out_ready = 1;
    for (int i = 0; i < 10 && ext_out_valid; i++) tick();
    checks++; if (popped.size() != 4 || (popped.size() == 4 && popped[3] !== 8'hA4)) begin failures++; $display("FAIL full_pop_drain got=%0d entries exp=4 ending a4", popped.size()); end
  endtask

  task automatic test_back_to_back();
    popped.delete(); ext_out_ready = 1;
    for (int i = 0; i < 20; i++) begin cpu_wr = 1; cpu_wr_data = 8'h80 + DW'(i); tick(); end
    cpu_wr = 0;
    checks++; if ({ext_out_valid, cpu_wr_ready, ext_out} !== {2'b11, 8'h93}) begin failures++; $display("FAIL b2b_tail got=%b/%b/%h exp=1/1/93", ext_out_valid, cpu_wr_ready, ext_out); end
    tick();
    checks++; if (popped.size() != 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", popped.size()); end
    for (int i = 0; i < 20 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== 8'h80 + DW'(i)) begin failures++; $display("FAIL b2b_seq[%0d] got=%h exp=%h", i, popped[i], 8'h80 + DW'(i)); end
    end
    checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", out_overflow); end
    ext_out_ready = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin cpu_wr = 1; cpu_wr_data = 8'hC1 + DW'(i); tick(); end
    cpu_wr = 0; rst = 1; tick(); rst = 0;
    checks++; if ({ext_out_valid, cpu_wr_ready, out_overflow, in_changed} !== {3'b010, 3'b000}) begin failures++; $display("FAIL mid_rst got=%b/%b/%b/%b exp=0/1/0/000", ext_out_valid, cpu_wr_ready, out_overflow, in_changed); end
    cpu_wr = 1; cpu_wr_data = 8'h77; tick(); cpu_wr = 0;
    checks++; if ({ext_out_valid, ext_out} !== {1'b1, 8'h77}) begin failures++; $display("FAIL post_rst_push got=%b/%h exp=1/77", ext_out_valid, ext_out); end
    ext_out_ready = 1; tick(); ext_out_ready = 0; tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_fifo_full();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
